// File: rtl/ttt_pkg.sv
// ---------------------------------------------------------------------------
// ttt_pkg
// Shared types and constants for the tic-tac-toe game controller.
//   board_t    : 9-bit board, bit i = cell i (cell 0 is the leftmost bit).
//   state_t    : controller states IDLE / PLAY / CHECK / DONE.
//   winner_t   : result codes 00 none, 01 P1, 10 P2, 11 draw.
//   LINE_MASKS : the 8 winning lines (3 rows, 3 columns, 2 diagonals).
//   cell_mask  : one-hot board mask for a cell index (all-zero above 8).
// ---------------------------------------------------------------------------
package ttt_pkg;

  localparam int CELLS     = 9;
  localparam int NUM_LINES = 8;

  typedef logic [0:CELLS-1] board_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam board_t LINE_MASKS [NUM_LINES] = '{
    9'b111000000,  // row 0
    9'b000111000,  // row 1
    9'b000000111,  // row 2
    9'b100100100,  // column 0
    9'b010010010,  // column 1
    9'b001001001,  // column 2
    9'b100010001,  // diagonal 0-4-8
    9'b001010100   // diagonal 2-4-6
  };

  // Cell 0 sits at the leftmost bit, so shifting the top bit right by the
  // index lands on the right cell; indices above 8 shift out to zero.
  function automatic board_t cell_mask(input logic [3:0] pos);
    return board_t'(9'b100000000 >> pos);
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl_if
// Move-entry handshake between the front end (master) and the game
// controller (slave). A move transfers on a cycle with move_valid and
// move_ready both high.
//   move_valid : move request qualifier            (master -> slave)
//   move_pos   : cell index 0..8, row-major         (master -> slave)
//   move_ready : controller can accept a move       (slave -> master)
// ---------------------------------------------------------------------------
interface ttt_game_ctrl_if;

  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;

  modport master (output move_valid, output move_pos, input move_ready);
  modport slave  (input move_valid, input move_pos, output move_ready);

endinterface

// File: rtl/ttt_line_check.sv
// ---------------------------------------------------------------------------
// ttt_line_check
// Combinational win detector: win is high when the board fully covers any
// of the 8 lines in LINE_MASKS.
//   board : one player's occupied cells
//   win   : that player holds a complete line
// ---------------------------------------------------------------------------
module ttt_line_check
  import ttt_pkg::*;
(
  input  board_t board,
  output logic   win
);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if ((board & LINE_MASKS[i]) == LINE_MASKS[i]) win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
// Sequencing controller for one two-player tic-tac-toe game. Holds both
// boards, validates moves, alternates turns and reports win/draw.
//   clk, rst   : clock and synchronous active-high reset
//   start      : one-cycle pulse, clears the board and starts a game
//   move_if    : move handshake (move_valid, move_pos, move_ready)
//   board_p1/2 : occupied cells per player, bit i = cell i
//   turn       : player to move (0 = P1, 1 = P2)
//   move_count : accepted moves in this game, 0..9
//   illegal    : one-cycle pulse after a rejected move (or a forfeit)
//   game_over  : high while the game is finished
//   winner     : 00 none, 01 P1, 10 P2, 11 draw
// Optional feature macro TTT_TURN_TIMEOUT_EN: a player idle for
// TIMEOUT_CYCLES cycles in PLAY forfeits the turn.
// ---------------------------------------------------------------------------
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER   = 1'b0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  ttt_game_ctrl_if.slave        move_if,
  output board_t                board_p1,
  output board_t                board_p2,
  output logic                  turn,
  output logic [3:0]            move_count,
  output logic                  illegal,
  output logic                  game_over,
  output logic [1:0]            winner
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ttt_game_ctrl: TIMEOUT_CYCLES must be >= 2");
  end

  state_t     state_q, state_d;
  board_t     p1_q, p1_d, p2_q, p2_d;
  logic       turn_q, turn_d;
  logic [3:0] count_q, count_d;
  winner_t    winner_q, winner_d;
  logic       illegal_q, illegal_d;

`ifdef TTT_TURN_TIMEOUT_EN
  localparam int             TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  board_t mover_board;
  logic   mover_wins;
  logic   move_legal;

  // During CHECK turn still names the player who just moved.
  assign mover_board = turn_q ? p2_q : p1_q;

  ttt_line_check u_line_check (
    .board (mover_board),
    .win   (mover_wins)
  );

  assign move_legal = (move_if.move_pos <= 4'd8) &&
                      (((p1_q | p2_q) & cell_mask(move_if.move_pos)) == '0);

  always_comb begin
    state_d   = state_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    turn_d    = turn_q;
    count_d   = count_q;
    winner_d  = winner_q;
    illegal_d = 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
    timer_d   = timer_q;
`endif

    // start outranks any move offered in the same cycle.
    if (start) begin
      state_d  = PLAY;
      p1_d     = '0;
      p2_d     = '0;
      turn_d   = FIRST_PLAYER;
      count_d  = '0;
      winner_d = WIN_NONE;
`ifdef TTT_TURN_TIMEOUT_EN
      timer_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        PLAY: begin
          if (move_if.move_valid) begin
            if (move_legal) begin
              if (turn_q) p2_d = p2_q | cell_mask(move_if.move_pos);
              else        p1_d = p1_q | cell_mask(move_if.move_pos);
              count_d = count_q + 4'd1;
              state_d = CHECK;
            end else begin
              illegal_d = 1'b1;
`ifdef TTT_TURN_TIMEOUT_EN
              timer_d   = '0;
`endif
            end
          end
`ifdef TTT_TURN_TIMEOUT_EN
          // An accepted move on the expiry cycle takes the branch above,
          // so the forfeit only fires when nothing was offered.
          else if (timer_q == TIMER_MAX) begin
            illegal_d = 1'b1;
            turn_d    = ~turn_q;
            timer_d   = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
`endif
        end
        CHECK: begin
          // A completed line beats the 9-move draw rule.
          if (mover_wins) begin
            winner_d = turn_q ? WIN_P2 : WIN_P1;
            state_d  = DONE;
          end else if (count_q == 4'd9) begin
            winner_d = WIN_DRAW;
            state_d  = DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = PLAY;
`ifdef TTT_TURN_TIMEOUT_EN
            timer_d = '0;
`endif
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      p1_q      <= '0;
      p2_q      <= '0;
      turn_q    <= FIRST_PLAYER;
      count_q   <= '0;
      winner_q  <= WIN_NONE;
      illegal_q <= 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      turn_q    <= turn_d;
      count_q   <= count_d;
      winner_q  <= winner_d;
      illegal_q <= illegal_d;
`ifdef TTT_TURN_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

  assign move_if.move_ready = (state_q == PLAY);
  assign game_over          = (state_q == DONE);
  assign board_p1           = p1_q;
  assign board_p2           = p2_q;
  assign turn               = turn_q;
  assign move_count         = count_q;
  assign illegal            = illegal_q;
  assign winner             = winner_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ttt_game_ctrl
// Self-checking bench for ttt_game_ctrl: a table of cycle vectors, a few
// hand-written game sequences, and a randomized run compared against a
// rules-level model of the game. Outputs are compared as one packed word
// {ready, illegal, game_over, turn, winner, move_count, board_p1, board_p2}.
// ---------------------------------------------------------------------------
module tb_ttt_game_ctrl;
  import ttt_pkg::*;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  board_t     board_p1, board_p2;
  logic       turn;
  logic [3:0] move_count;
  logic       illegal;
  logic       game_over;
  logic [1:0] winner;

  ttt_game_ctrl_if bus ();

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .move_if    (bus),
    .board_p1   (board_p1),
    .board_p2   (board_p2),
    .turn       (turn),
    .move_count (move_count),
    .illegal    (illegal),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [27:0] pk(bit rdy, bit ill, bit go, bit tn,
                                     logic [1:0] w, logic [3:0] c,
                                     logic [0:8] b1, logic [0:8] b2);
    return {rdy, ill, go, tn, w, c, b1, b2};
  endfunction

  function automatic logic [27:0] dut_pk();
    return pk(bus.move_ready, illegal, game_over, turn, winner, move_count,
              board_p1, board_p2);
  endfunction

  task automatic check(input string name, input logic [27:0] act,
                       input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (rdy,ill,over,turn,win,cnt,p1,p2)",
               name, act, exp);
    end
  endtask

  // Drive inputs for one edge, then release them 1 time unit after it.
  task automatic cycle(input bit r, input bit s, input bit v, input logic [3:0] p);
    rst = r; start = s; bus.move_valid = v; bus.move_pos = p;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; bus.move_valid = 1'b0; bus.move_pos = 4'd0;
  endtask

  task automatic do_move(input logic [3:0] p);
    cycle(1'b0, 1'b0, 1'b1, p);
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // ---------------- rules-level reference model ----------------
  int m_cell [9];   // 0 empty, 1 P1, 2 P2
  bit m_turn, m_ill, m_active, m_pending, m_over;
  int m_count, m_winner, m_idle;

  function automatic void m_reset();
    foreach (m_cell[i]) m_cell[i] = 0;
    m_turn = 1'b0; m_ill = 1'b0; m_active = 1'b0; m_pending = 1'b0;
    m_over = 1'b0; m_count = 0; m_winner = 0; m_idle = 0;
  endfunction

  function automatic bit m_has_line(int who);
    for (int k = 0; k < 3; k++) begin
      if (m_cell[3*k] == who && m_cell[3*k+1] == who && m_cell[3*k+2] == who) return 1'b1;
      if (m_cell[k] == who && m_cell[k+3] == who && m_cell[k+6] == who) return 1'b1;
    end
    if (m_cell[0] == who && m_cell[4] == who && m_cell[8] == who) return 1'b1;
    if (m_cell[2] == who && m_cell[4] == who && m_cell[6] == who) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_step(bit r, bit s, bit v, int pos);
    int who;
    if (r) begin m_reset(); return; end
    m_ill = 1'b0;
    if (s) begin
      foreach (m_cell[i]) m_cell[i] = 0;
      m_turn = 1'b0; m_count = 0; m_winner = 0;
      m_active = 1'b1; m_pending = 1'b0; m_over = 1'b0; m_idle = 0;
      return;
    end
    if (!m_active || m_over) return;
    who = int'(m_turn) + 1;
    if (m_pending) begin
      m_pending = 1'b0;
      if (m_has_line(who))    begin m_winner = who; m_over = 1'b1; end
      else if (m_count == 9)  begin m_winner = 3;   m_over = 1'b1; end
      else                    begin m_turn = ~m_turn; m_idle = 0; end
      return;
    end
    if (v && pos <= 8 && m_cell[pos] == 0) begin
      m_cell[pos] = who; m_count++; m_pending = 1'b1;
      return;
    end
    if (v) begin m_ill = 1'b1; m_idle = 0; return; end
`ifdef TTT_TURN_TIMEOUT_EN
    if (m_idle == T - 1) begin m_ill = 1'b1; m_turn = ~m_turn; m_idle = 0; end
    else m_idle++;
`endif
  endfunction

  function automatic logic [27:0] m_pk();
    logic [0:8] b1, b2;
    for (int i = 0; i < 9; i++) begin
      b1[i] = (m_cell[i] == 1);
      b2[i] = (m_cell[i] == 2);
    end
    return pk(m_active && !m_pending && !m_over, m_ill, m_over, m_turn,
              2'(m_winner), 4'(m_count), b1, b2);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit         r, s, v;
    logic [3:0] p;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vv(bit r, bit s, bit v, logic [3:0] p, logic [27:0] e);
    vec_t x;
    x.r = r; x.s = s; x.v = v; x.p = p; x.exp = e;
    return x;
  endfunction

  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int win9_seq [9] = '{0, 3, 2, 4, 5, 7, 6, 8, 1};
  int diag_seq [6] = '{0, 2, 1, 4, 5, 6};

  initial begin
    rst = 1'b0; start = 1'b0; bus.move_valid = 1'b0; bus.move_pos = 4'd0;

    // Row-0 win for P1, then illegal moves, then rst during CHECK.
    vecs.push_back(vv(1,0,0,0, pk(0,0,0,0,2'b00,0,9'b000000000,9'b000000000)));
    vecs.push_back(vv(0,1,0,0, pk(1,0,0,0,2'b00,0,9'b000000000,9'b000000000)));
    vecs.push_back(vv(0,0,1,0, pk(0,0,0,0,2'b00,1,9'b100000000,9'b000000000)));
    vecs.push_back(vv(0,0,0,0, pk(1,0,0,1,2'b00,1,9'b100000000,9'b000000000)));
    vecs.push_back(vv(0,0,1,3, pk(0,0,0,1,2'b00,2,9'b100000000,9'b000100000)));
    vecs.push_back(vv(0,0,0,0, pk(1,0,0,0,2'b00,2,9'b100000000,9'b000100000)));
    vecs.push_back(vv(0,0,1,1, pk(0,0,0,0,2'b00,3,9'b110000000,9'b000100000)));
    vecs.push_back(vv(0,0,0,0, pk(1,0,0,1,2'b00,3,9'b110000000,9'b000100000)));
    vecs.push_back(vv(0,0,1,4, pk(0,0,0,1,2'b00,4,9'b110000000,9'b000110000)));
    vecs.push_back(vv(0,0,0,0, pk(1,0,0,0,2'b00,4,9'b110000000,9'b000110000)));
    vecs.push_back(vv(0,0,1,2, pk(0,0,0,0,2'b00,5,9'b111000000,9'b000110000)));
    vecs.push_back(vv(0,0,0,0, pk(0,0,1,0,2'b01,5,9'b111000000,9'b000110000)));
    vecs.push_back(vv(0,0,1,5, pk(0,0,1,0,2'b01,5,9'b111000000,9'b000110000)));
    vecs.push_back(vv(0,1,0,0, pk(1,0,0,0,2'b00,0,9'b000000000,9'b000000000)));
    vecs.push_back(vv(0,0,1,4, pk(0,0,0,0,2'b00,1,9'b000010000,9'b000000000)));
    vecs.push_back(vv(0,0,0,0, pk(1,0,0,1,2'b00,1,9'b000010000,9'b000000000)));
    vecs.push_back(vv(0,0,1,4, pk(1,1,0,1,2'b00,1,9'b000010000,9'b000000000)));
    vecs.push_back(vv(0,0,0,0, pk(1,0,0,1,2'b00,1,9'b000010000,9'b000000000)));
    vecs.push_back(vv(0,0,1,9, pk(1,1,0,1,2'b00,1,9'b000010000,9'b000000000)));
    vecs.push_back(vv(0,0,1,15,pk(1,1,0,1,2'b00,1,9'b000010000,9'b000000000)));
    vecs.push_back(vv(0,0,0,0, pk(1,0,0,1,2'b00,1,9'b000010000,9'b000000000)));
    vecs.push_back(vv(0,0,1,0, pk(0,0,0,1,2'b00,2,9'b000010000,9'b100000000)));
    vecs.push_back(vv(0,0,1,1, pk(1,0,0,0,2'b00,2,9'b000010000,9'b100000000)));
    vecs.push_back(vv(0,0,1,1, pk(0,0,0,0,2'b00,3,9'b010010000,9'b100000000)));
    vecs.push_back(vv(1,0,1,2, pk(0,0,0,0,2'b00,0,9'b000000000,9'b000000000)));
    vecs.push_back(vv(0,0,1,2, pk(0,0,0,0,2'b00,0,9'b000000000,9'b000000000)));
    vecs.push_back(vv(0,1,1,0, pk(1,0,0,0,2'b00,0,9'b000000000,9'b000000000)));
    vecs.push_back(vv(1,0,0,0, pk(0,0,0,0,2'b00,0,9'b000000000,9'b000000000)));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].p);
      check($sformatf("vec%0d", i), dut_pk(), vecs[i].exp);
    end

    // Full board with no line: draw.
    cycle(1'b0, 1'b1, 1'b0, 4'd0);
    foreach (draw_seq[i]) do_move(4'(draw_seq[i]));
    check("draw", dut_pk(), pk(0,0,1,0,2'b11,9,9'b101100011,9'b010011100));

    // Win completed by the 9th move reports the win.
    cycle(1'b0, 1'b1, 1'b0, 4'd0);
    foreach (win9_seq[i]) do_move(4'(win9_seq[i]));
    check("win_on_9th", dut_pk(), pk(0,0,1,0,2'b01,9,9'b111001100,9'b000110011));

    // P2 diagonal win, move in DONE ignored, start clears.
    cycle(1'b0, 1'b1, 1'b0, 4'd0);
    foreach (diag_seq[i]) do_move(4'(diag_seq[i]));
    check("p2_diag", dut_pk(), pk(0,0,1,1,2'b10,6,9'b110001000,9'b001010100));
    cycle(1'b0, 1'b0, 1'b1, 4'd7);
    check("done_ignores_move", dut_pk(), pk(0,0,1,1,2'b10,6,9'b110001000,9'b001010100));
    cycle(1'b0, 1'b1, 1'b0, 4'd0);
    check("restart", dut_pk(), pk(1,0,0,0,2'b00,0,9'b000000000,9'b000000000));

`ifdef TTT_TURN_TIMEOUT_EN
    // Idle turn: forfeit on the T-th PLAY cycle edge.
    for (int i = 0; i < T - 1; i++) cycle(1'b0, 1'b0, 1'b0, 4'd0);
    check("no_early_forfeit", dut_pk(), pk(1,0,0,0,2'b00,0,9'b000000000,9'b000000000));
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    check("forfeit", dut_pk(), pk(1,1,0,1,2'b00,0,9'b000000000,9'b000000000));
    // Move accepted on the expiry cycle: no forfeit.
    for (int i = 0; i < T - 1; i++) cycle(1'b0, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 1'b1, 4'd4);
    check("expiry_move", dut_pk(), pk(0,0,0,1,2'b00,1,9'b000000000,9'b000010000));
    cycle(1'b0, 1'b0, 1'b0, 4'd0);
    check("expiry_move_turn", dut_pk(), pk(1,0,0,0,2'b00,1,9'b000000000,9'b000010000));
`endif

    // Randomized run against the rules model.
    m_step(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 4'd0);
    check("rand_reset", dut_pk(), m_pk());
    for (int i = 0; i < 3000; i++) begin
      bit r, s, v;
      int p;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 2) != 0);
      p = $urandom_range(0, 11);
      m_step(r, s, v, p);
      cycle(r, s, v, 4'(p));
      check($sformatf("rand%0d", i), dut_pk(), m_pk());
      if ((board_p1 & board_p2) != '0) begin
        n_errors++;
        $display("FAIL overlap%0d: p1=%b p2=%b required disjoint", i, board_p1, board_p2);
      end
      n_checks++;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Sequencing controller for one two-player tic-tac-toe game.
- Owns both players' board registers and alternates turns.
- Accepts and validates cell moves, then evaluates win/draw after every accepted move.
- Sits between the move-entry front end (buttons/keypad decoder) and the display/result logic; its board outputs use the team's standard 9-bit board encoding.

Parameters:
- FIRST_PLAYER, 0, player who moves first after start (0 = P1, 1 = P2).
- TIMEOUT_CYCLES, 1000, per-turn idle limit in clk cycles; used only when TTT_TURN_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears the board and begins a new game.
- move_valid  in  1  move request qualifier.
- move_pos  in  4  cell index 0..8; 0-2 top row left to right, 3-5 middle row, 6-8 bottom row.
- move_ready  out  1  controller can accept a move this cycle.
- board_p1  out  [0:8]  P1 occupied cells; bit i = cell i.
- board_p2  out  [0:8]  P2 occupied cells.
- turn  out  1  player to move (0 = P1, 1 = P2).
- move_count  out  4  accepted moves in the current game, 0..9.
- illegal  out  1  one-cycle pulse: offered move rejected.
- game_over  out  1  high while in DONE.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw; valid while game_over is high.

Behaviour:
- Reset state: IDLE. Boards = 0, move_count = 0, turn = FIRST_PLAYER, winner = 00. move_ready, illegal and game_over all = 0.
- States:
  - IDLE: waits for start.
  - PLAY: move_ready = 1.
  - CHECK: lasts exactly one cycle; move_ready = 0.
  - DONE: game_over = 1; move_ready = 0.
- start in any state other than during rst: clears boards, move_count and winner; sets turn = FIRST_PLAYER; next state PLAY. start has priority over a simultaneous move (the move is dropped, no illegal pulse).
- PLAY, handshake move_valid & move_ready:
  - Legal (move_pos <= 8 and the cell is clear in both boards): set that bit in the mover's board, increment move_count, go to CHECK.
  - Otherwise: pulse illegal for 1 cycle, boards unchanged, stay in PLAY; turn does not change.
- Moves offered outside PLAY are ignored: no pulse, no state change.
- CHECK: evaluates the registered board of the player who just moved against the 8 lines (3 rows, 3 columns, 2 diagonals).
  - Win: winner = 01 or 10, go to DONE.
  - Else if move_count == 9: winner = 11, go to DONE.
  - Else: toggle turn, go to PLAY.
  - A win on the 9th move reports the win, not a draw.
- Latency: move accepted at edge N; board and move_count updated after edge N; result visible after edge N+1 (DONE, or PLAY with turn toggled). Maximum move rate is one per 2 cycles.
- DONE: all outputs hold until start or rst.
- rst asserted mid-game returns to the reset state on the next edge, overriding all other inputs.
- Invariant: board_p1 & board_p2 == 0 at all times.

Optional Feature:
- Macro: TTT_TURN_TIMEOUT_EN.
- Defined:
  - A turn counter runs in PLAY, cleared on entering PLAY and on any illegal attempt.
  - When it reaches TIMEOUT_CYCLES - 1 with no accepted move, the current player forfeits the turn: illegal pulses 1 cycle, turn toggles, move_count and boards are unchanged, and the counter restarts.
  - An accepted move in the same cycle as expiry wins; no forfeit occurs.
- Undefined: no counter logic; a turn waits indefinitely.

Decomposition:
- Shared package ttt_pkg:
  - State enum (IDLE, PLAY, CHECK, DONE).
  - Winner codes (WIN_NONE, WIN_P1, WIN_P2, WIN_DRAW).
  - CELLS = 9.
  - Array of the 8 line masks, each [0:8], e.g. row0 = 9'b111000000, diagonal = 9'b100010001.
- One sub-module, ttt_line_check: combinational, input board [0:8], output win = OR over masks of ((board & mask) == mask).
  - Instantiated once, fed by the mover's board, selected by turn.

Test Plan:
- rst, then start; P1 plays 0, P2 plays 3, P1 plays 1, P2 plays 4, P1 plays 2 -> after the last CHECK: game_over = 1, winner = 01, board_p1 = 9'b111000000, board_p2 = 9'b000110000, move_count = 5.
- P1 plays 4, then P2 plays 4 -> illegal pulses once, board_p2 stays 0, turn stays 1. A move with move_pos = 9 gives the same illegal response.
- Full-board sequence 0,1,2,4,3,5,7,6,8 (no line) -> winner = 11 after move 9, move_count = 9.
- P2 diagonal 2,4,6 with P1 filler 0,1,5 -> winner = 10 and move_ready = 0. A further move_valid in DONE is ignored; a subsequent start clears the boards and sets turn = 0.
- rst asserted in CHECK after 3 moves -> next cycle all outputs at reset values, state IDLE, and a move_valid is ignored.
- With TTT_TURN_TIMEOUT_EN and TIMEOUT_CYCLES = 8: start, no moves -> illegal pulse after 8 PLAY cycles, turn 0→1, boards unchanged. A move accepted on the expiry cycle gives no forfeit.
